ds_operand_stage: RTL and testbench
===================================

# ds_operand_stage

Parametrised decode-stage operand resolver and interlock, sitting between the IF stage and the EX pipeline register. It registers the fetched instruction with a valid/allow handshake and resolves rj/rk-or-rd operands against NUM_FWD in-flight writers in priority order. It stalls on not-yet-available results such as load-use, and resolves all LA32R branches and jumps with a single-shot redirect. A saturating stall counter is provided for performance analysis.

## Interface
- XLEN, 32, datapath width
- NUM_FWD, 3, number of forwarding sources; index 0 is youngest (EX), highest priority

- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- fs_valid  in  1  IF has an instruction
- fs_pc  in  XLEN  IF pc
- fs_inst  in  32  IF instruction
- ds_allow_in  out  1  stage can accept
- rf_raddr1 / rf_raddr2  out  5  register file read addresses (rj; rd for branch/store, else rk)
- rf_rdata1 / rf_rdata2  in  XLEN  register file data, same cycle
- fwd_valid, fwd_we, fwd_ready  in  NUM_FWD  per source: stage valid, writes a register, result available now
- fwd_waddr  in  5*NUM_FWD  per-source destination, packed, source i at [5i+4:5i]
- fwd_wdata  in  XLEN*NUM_FWD  per-source result, packed
- es_allow_in  in  1  EX accepts
- ds_to_es_valid  out  1  instruction leaves this cycle
- ds_pc, ds_inst  out  XLEN/32  held instruction
- ds_src1, ds_src2  out  XLEN  resolved operands
- br_taken  out  1  redirect IF (one cycle per branch)
- br_target  out  XLEN  redirect address
- stall_cnt  out  32  stall cycles

## Operation
- Registers: ds_valid, ds_pc, ds_inst. Load when ds_allow_in: ds_valid <= fs_valid & ~br_taken, pc/inst <= fs_*.
- ds_allow_in = ~ds_valid | (ready_go & es_allow_in); ds_to_es_valid = ds_valid & ready_go; fire = ds_to_es_valid & es_allow_in.
- Usage: rj read unless b, bl, lu12i.w, pcaddu12i. Second port is read for the following: 3R ops (op[31:26]=0, [25:22]=0, [21:20]=1), beq/bne/blt/bge/bltu/bgeu (0x16–0x1b) and st.b/h/w (0x0a, [25:22]=4/5/6). For the branches and stores it reads rd.
- Match i per port: fwd_valid[i] & fwd_we[i] & waddr≠0 & waddr==raddr & port used. Only the lowest matching index is considered.
- Matched & fwd_ready → operand = fwd_wdata[i]. Matched & ~ready → hazard, even if an older source has data. No match → rf_rdata. raddr 0 → 0.
- ready_go = ~hazard on either used port.
- Branches: beq/bne equality; blt/bge signed; bltu/bgeu unsigned; b, bl, jirl always taken.
- br_taken = fire & taken. It is never asserted while stalled, so each instruction redirects once.
- Target: pc + sext(offs16<<2) for conditional branches; pc + sext(offs26<<2) for b/bl; ds_src1 + sext(offs16<<2) for jirl. Arithmetic is modulo 2^XLEN.
- Instruction accepted from IF in the br_taken cycle is squashed (ds_valid=0).
- stall_cnt increments each cycle ds_valid & ~ready_go; saturates at 0xFFFFFFFF.

## Timing
- Reset values: ds_valid 0, ds_pc 0, ds_inst 0, stall_cnt 0. Hence ds_allow_in 1, ds_to_es_valid 0, br_taken 0.
- Operand resolve, hazard and branch decision are combinational from the registered instruction: zero latency. IF→EX minimum 1 cycle in stage.
- Hazard and es_allow_in low together: hold all registers and outputs stable.
- Reset mid-stall clears ds_valid; no br_taken that cycle.

## Configuration
- DS_FWD_EN defined: forwarding as above.
- Undefined: no bypass. Any match, ready or not, is a hazard, so the stage waits until no in-flight writer matches. Operands always come from rf_rdata, and fwd_wdata is unused.

## Test plan
- Reset, then fs_valid=1, inst add.w r3,r1,r2 at pc 0x1c000000, es_allow_in=1 → ds_to_es_valid next cycle, stall_cnt=0.
- Source0 writes r1=0x10 ready, source2 writes r1=0x99 → ds_src1=0x10 (with DS_FWD_EN). Without DS_FWD_EN the stage stalls until both are cleared.
- Load-use: source0 r5 ready=0 for 1 cycle, then ready with 0xABCD → 1 stall cycle, stall_cnt=1, ds_src1=0xABCD.
- blt r1=0xFFFFFFFF, r2=1 → taken; bltu with the same operands → not taken. beq at pc 0x100, offs16=4 → br_target=0x110.
- jirl with rj forwarded 0x2000, offs16=-1 → br_target=0x1FFC. Simultaneous fs_valid is squashed, and br_taken pulses exactly 1 cycle even when es_allow_in is low for 3 cycles first.
- Write to r0 from all sources → no hazard, operand 0.

Source files
------------

// File: rtl/ds_operand_stage.sv
// Decode-stage operand resolver, interlock and LA32R branch unit.
// Optional macro DS_FWD_EN enables bypass from the in-flight writers; undefined means interlock only.
module ds_operand_stage #(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned NUM_FWD = 3
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    fs_valid,
    input  logic [XLEN-1:0]         fs_pc,
    input  logic [31:0]             fs_inst,
    output logic                    ds_allow_in,
    output logic [4:0]              rf_raddr1,
    output logic [4:0]              rf_raddr2,
    input  logic [XLEN-1:0]         rf_rdata1,
    input  logic [XLEN-1:0]         rf_rdata2,
    input  logic [NUM_FWD-1:0]      fwd_valid,
    input  logic [NUM_FWD-1:0]      fwd_we,
    input  logic [NUM_FWD-1:0]      fwd_ready,
    input  logic [5*NUM_FWD-1:0]    fwd_waddr,
    input  logic [XLEN*NUM_FWD-1:0] fwd_wdata,
    input  logic                    es_allow_in,
    output logic                    ds_to_es_valid,
    output logic [XLEN-1:0]         ds_pc,
    output logic [31:0]             ds_inst,
    output logic [XLEN-1:0]         ds_src1,
    output logic [XLEN-1:0]         ds_src2,
    output logic                    br_taken,
    output logic [XLEN-1:0]         br_target,
    output logic [31:0]             stall_cnt
);

    typedef struct packed {
        logic            hazard;
        logic [XLEN-1:0] data;
    } port_res_t;

    logic            ds_valid;
    logic            ready_go;
    logic            fire;
    logic            taken;
    logic [5:0]      op6;
    logic [6:0]      op7;
    logic            is_b, is_bl, is_jirl;
    logic            is_beq, is_bne, is_blt, is_bge, is_bltu, is_bgeu;
    logic            is_cond_br, is_3r, is_store, is_lu12i, is_pcadd;
    logic            use1, use2;
    port_res_t       res1, res2;
    logic [XLEN-1:0] offs16_x, offs26_x;

    // Instruction class decode from the held instruction
    assign op6        = ds_inst[31:26];
    assign op7        = ds_inst[31:25];
    assign is_jirl    = (op6 == 6'h13);
    assign is_b       = (op6 == 6'h14);
    assign is_bl      = (op6 == 6'h15);
    assign is_beq     = (op6 == 6'h16);
    assign is_bne     = (op6 == 6'h17);
    assign is_blt     = (op6 == 6'h18);
    assign is_bge     = (op6 == 6'h19);
    assign is_bltu    = (op6 == 6'h1a);
    assign is_bgeu    = (op6 == 6'h1b);
    assign is_cond_br = is_beq | is_bne | is_blt | is_bge | is_bltu | is_bgeu;
    assign is_3r      = (op6 == 6'h00) && (ds_inst[25:22] == 4'd0) && (ds_inst[21:20] == 2'b01);
    assign is_store   = (op6 == 6'h0a) &&
                        ((ds_inst[25:22] == 4'd4) || (ds_inst[25:22] == 4'd5) || (ds_inst[25:22] == 4'd6));
    assign is_lu12i   = (op7 == 7'b0001010);
    assign is_pcadd   = (op7 == 7'b0001110);

    assign use1      = ~(is_b | is_bl | is_lu12i | is_pcadd);
    assign use2      = is_3r | is_cond_br | is_store;
    assign rf_raddr1 = ds_inst[9:5];
    assign rf_raddr2 = (is_cond_br | is_store) ? ds_inst[4:0] : ds_inst[14:10];

    // Only the youngest matching writer is considered; an older one is never used to skip a stall
    function automatic port_res_t resolve(input logic [4:0]      raddr,
                                          input logic            used,
                                          input logic [XLEN-1:0] rdata);
        port_res_t res;
        logic      found;
        res.hazard = 1'b0;
        res.data   = (raddr == 5'd0) ? '0 : rdata;
        found      = 1'b0;
        for (int i = 0; i < int'(NUM_FWD); i++) begin
            if (!found && used && fwd_valid[i] && fwd_we[i] &&
                (fwd_waddr[5*i +: 5] != 5'd0) && (fwd_waddr[5*i +: 5] == raddr)) begin
                found = 1'b1;
`ifdef DS_FWD_EN
                if (fwd_ready[i]) begin
                    res.data = fwd_wdata[XLEN*i +: XLEN];
                end else begin
                    res.hazard = 1'b1;
                end
`else
                res.hazard = 1'b1;
`endif
            end
        end
        return res;
    endfunction

`ifndef DS_FWD_EN
    logic unused_fwd;
    assign unused_fwd = ^{fwd_ready, fwd_wdata};
`endif

    always_comb begin
        res1 = resolve(rf_raddr1, use1, rf_rdata1);
        res2 = resolve(rf_raddr2, use2, rf_rdata2);
    end

    assign ds_src1 = res1.data;
    assign ds_src2 = res2.data;

    assign ready_go       = ~(res1.hazard | res2.hazard);
    assign ds_to_es_valid = ds_valid & ready_go;
    assign fire           = ds_to_es_valid & es_allow_in;
    assign ds_allow_in    = ~ds_valid | (ready_go & es_allow_in);

    // Branch condition: rj in ds_src1, rd in ds_src2
    always_comb begin
        taken = is_b | is_bl | is_jirl;
        if (is_beq)  taken = (ds_src1 == ds_src2);
        if (is_bne)  taken = (ds_src1 != ds_src2);
        if (is_blt)  taken = ($signed(ds_src1) <  $signed(ds_src2));
        if (is_bge)  taken = ($signed(ds_src1) >= $signed(ds_src2));
        if (is_bltu) taken = (ds_src1 <  ds_src2);
        if (is_bgeu) taken = (ds_src1 >= ds_src2);
    end

    assign offs16_x = {{(XLEN-18){ds_inst[25]}}, ds_inst[25:10], 2'b00};
    assign offs26_x = {{(XLEN-28){ds_inst[9]}}, ds_inst[9:0], ds_inst[25:10], 2'b00};

    always_comb begin
        br_target = ds_pc + offs16_x;
        if (is_jirl) begin
            br_target = ds_src1 + offs16_x;
        end else if (is_b | is_bl) begin
            br_target = ds_pc + offs26_x;
        end
    end

    // Redirect only on the leaving cycle so a stalled branch pulses once
    assign br_taken = fire & taken & ~reset;

    always_ff @(posedge clk) begin
        if (reset) begin
            ds_valid  <= 1'b0;
            ds_pc     <= '0;
            ds_inst   <= '0;
            stall_cnt <= '0;
        end else begin
            if (ds_allow_in) begin
                ds_valid <= fs_valid & ~br_taken;
                ds_pc    <= fs_pc;
                ds_inst  <= fs_inst;
            end
            if (ds_valid && !ready_go && (stall_cnt != 32'hFFFF_FFFF)) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_ds_operand_stage.sv
// Self-checking bench for ds_operand_stage: directed scenarios plus randomized traffic
// compared each cycle against a behavioural model of the decode stage.
module tb_ds_operand_stage;
    localparam int unsigned XLEN    = 32;
    localparam int unsigned NUM_FWD = 3;

    logic                    clk = 1'b0;
    logic                    reset;
    logic                    fs_valid;
    logic [XLEN-1:0]         fs_pc;
    logic [31:0]             fs_inst;
    logic                    ds_allow_in;
    logic [4:0]              rf_raddr1, rf_raddr2;
    logic [XLEN-1:0]         rf_rdata1, rf_rdata2;
    logic [NUM_FWD-1:0]      fwd_valid, fwd_we, fwd_ready;
    logic [5*NUM_FWD-1:0]    fwd_waddr;
    logic [XLEN*NUM_FWD-1:0] fwd_wdata;
    logic                    es_allow_in;
    logic                    ds_to_es_valid;
    logic [XLEN-1:0]         ds_pc;
    logic [31:0]             ds_inst;
    logic [XLEN-1:0]         ds_src1, ds_src2;
    logic                    br_taken;
    logic [XLEN-1:0]         br_target;
    logic [31:0]             stall_cnt;

    logic [31:0] rf [32];
    assign rf_rdata1 = rf[rf_raddr1];
    assign rf_rdata2 = rf[rf_raddr2];

    int n_vec = 0;
    int n_err = 0;

    // Model state: what the stage should be holding
    logic        m_valid;
    logic [31:0] m_pc, m_inst, m_stall;

    ds_operand_stage #(.XLEN(XLEN), .NUM_FWD(NUM_FWD)) dut (
        .clk(clk), .reset(reset),
        .fs_valid(fs_valid), .fs_pc(fs_pc), .fs_inst(fs_inst),
        .ds_allow_in(ds_allow_in),
        .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
        .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
        .fwd_valid(fwd_valid), .fwd_we(fwd_we), .fwd_ready(fwd_ready),
        .fwd_waddr(fwd_waddr), .fwd_wdata(fwd_wdata),
        .es_allow_in(es_allow_in),
        .ds_to_es_valid(ds_to_es_valid),
        .ds_pc(ds_pc), .ds_inst(ds_inst),
        .ds_src1(ds_src1), .ds_src2(ds_src2),
        .br_taken(br_taken), .br_target(br_target),
        .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] add_w(input logic [4:0] d, input logic [4:0] j, input logic [4:0] k);
        return {17'h00020, k, j, d};
    endfunction

    function automatic logic [31:0] br_inst(input logic [5:0] op, input logic [4:0] j,
                                           input logic [4:0] d, input logic [15:0] o);
        return {op, o, j, d};
    endfunction

    function automatic logic [31:0] rand_inst();
        logic [4:0]  d = 5'($urandom_range(0, 5));
        logic [4:0]  j = 5'($urandom_range(0, 5));
        logic [4:0]  k = 5'($urandom_range(0, 5));
        logic [15:0] o = 16'($urandom);
        case ($urandom_range(0, 9))
            0, 1:    return add_w(d, j, k);
            2:       return br_inst(6'(6'h16 + $urandom_range(0, 5)), j, d, o);
            3:       return br_inst(6'h13, j, d, o);
            4:       return {6'(6'h14 + $urandom_range(0, 1)), o, 10'($urandom)};
            5:       return {6'h0a, 4'(4 + $urandom_range(0, 2)), 12'($urandom), j, d};
            6:       return {7'h0a, 20'($urandom), d};
            7:       return {7'h0e, 20'($urandom), d};
            8:       return {10'h00a, 12'($urandom), j, d};
            default: return $urandom;
        endcase
    endfunction

    // Youngest matching writer decides: data if ready, else a stall (or always a stall without bypass)
    task automatic resolve(input bit used, input logic [4:0] a, output bit haz, output logic [31:0] val);
        int hit;
        hit = -1;
        val = (a == 5'd0) ? 32'h0 : rf[a];
        haz = 1'b0;
        if (!used || a == 5'd0) return;
        for (int i = NUM_FWD - 1; i >= 0; i--)
            if (fwd_valid[i] && fwd_we[i] && fwd_waddr[5*i +: 5] == a) hit = i;
        if (hit < 0) return;
`ifdef DS_FWD_EN
        if (fwd_ready[hit]) val = fwd_wdata[XLEN*hit +: XLEN];
        else haz = 1'b1;
`else
        haz = 1'b1;
`endif
    endtask

    // Compare all outputs against the model for the current inputs, then advance the model
    task automatic eval();
        logic [5:0]  op;
        logic [4:0]  a1, a2;
        logic [31:0] v1, v2, tgt;
        bit          use1, use2, rd_second, h1, h2, rgo, exp_go, fire, exp_allow, taken, exp_br;
        int          o16, o26;
        #1;
        op        = m_inst[31:26];
        use1      = !(op inside {6'h14, 6'h15} || m_inst[31:25] inside {7'h0a, 7'h0e});
        rd_second = (op inside {[6'h16:6'h1b]}) || (op == 6'h0a && m_inst[25:22] inside {[4'd4:4'd6]});
        use2      = rd_second || (m_inst[31:20] == 12'h001);
        a1        = m_inst[9:5];
        a2        = rd_second ? m_inst[4:0] : m_inst[14:10];
        resolve(use1, a1, h1, v1);
        resolve(use2, a2, h2, v2);
        rgo       = !(h1 || h2);
        exp_go    = m_valid && rgo;
        fire      = exp_go && es_allow_in;
        exp_allow = !m_valid || fire;
        case (op)
            6'h13, 6'h14, 6'h15: taken = 1'b1;
            6'h16:   taken = (v1 == v2);
            6'h17:   taken = (v1 != v2);
            6'h18:   taken = (int'(v1) <  int'(v2));
            6'h19:   taken = (int'(v1) >= int'(v2));
            6'h1a:   taken = (v1 <  v2);
            6'h1b:   taken = (v1 >= v2);
            default: taken = 1'b0;
        endcase
        exp_br = fire && taken && !reset;
        o16 = int'($signed(m_inst[25:10]));
        o26 = int'($signed({m_inst[9:0], m_inst[25:10]}));
        if (op == 6'h13)                     tgt = v1 + 32'(o16 * 4);
        else if (op inside {6'h14, 6'h15})   tgt = m_pc + 32'(o26 * 4);
        else                                 tgt = m_pc + 32'(o16 * 4);

        check("raddr1", 32'(rf_raddr1), 32'(a1));
        check("raddr2", 32'(rf_raddr2), 32'(a2));
        check("allow_in", 32'(ds_allow_in), 32'(exp_allow));
        check("to_es_valid", 32'(ds_to_es_valid), 32'(exp_go));
        check("br_taken", 32'(br_taken), 32'(exp_br));
        check("ds_pc", ds_pc, m_pc);
        check("ds_inst", ds_inst, m_inst);
        check("stall_cnt", stall_cnt, m_stall);
        if (exp_go && use1) check("src1", ds_src1, v1);
        if (exp_go && use2) check("src2", ds_src2, v2);
        if (exp_br)         check("br_target", br_target, tgt);

        if (reset) begin
            m_valid = 1'b0; m_pc = '0; m_inst = '0; m_stall = '0;
        end else begin
            if (m_valid && !rgo && m_stall != 32'hFFFF_FFFF) m_stall++;
            if (exp_allow) begin
                m_valid = fs_valid && !exp_br;
                m_pc    = fs_pc;
                m_inst  = fs_inst;
            end
        end
    endtask

    task automatic adv();
        @(negedge clk);
    endtask

    task automatic step();
        eval();
        adv();
    endtask

    task automatic idle();
        reset = 1'b0; fs_valid = 1'b0; fs_pc = '0; fs_inst = '0; es_allow_in = 1'b1;
        fwd_valid = '0; fwd_we = '0; fwd_ready = '0; fwd_waddr = '0; fwd_wdata = '0;
    endtask

    task automatic set_fwd(input int i, input logic [4:0] a, input bit rdy, input logic [31:0] d);
        fwd_valid[i] = 1'b1;
        fwd_we[i]    = 1'b1;
        fwd_ready[i] = rdy;
        fwd_waddr[5*i +: 5]       = a;
        fwd_wdata[XLEN*i +: XLEN] = d;
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b1;
        step();
        idle();
    endtask

    task automatic load(input logic [31:0] inst, input logic [31:0] pc);
        fs_valid = 1'b1; fs_inst = inst; fs_pc = pc;
        step();
        idle();
    endtask

    initial begin
        for (int r = 0; r < 32; r++) rf[r] = $urandom;
        idle();
        reset = 1'b1;
        m_valid = 1'b0; m_pc = '0; m_inst = '0; m_stall = '0;
        @(negedge clk);

        // Reset state
        do_reset();
        eval();
        check("rst_allow_in", 32'(ds_allow_in), 32'd1);
        check("rst_to_es_valid", 32'(ds_to_es_valid), 32'd0);
        check("rst_br_taken", 32'(br_taken), 32'd0);
        check("rst_stall_cnt", stall_cnt, 32'd0);
        adv();

        // add.w r3,r1,r2 passes through in one cycle
        load(add_w(5'd3, 5'd1, 5'd2), 32'h1c00_0000);
        eval();
        check("add_to_es_valid", 32'(ds_to_es_valid), 32'd1);
        check("add_pc", ds_pc, 32'h1c00_0000);
        check("add_stall_cnt", stall_cnt, 32'd0);
        adv();

        // Priority: source 0 wins over source 2 for r1
        do_reset();
        load(add_w(5'd3, 5'd1, 5'd2), 32'h1c00_0004);
        set_fwd(0, 5'd1, 1'b1, 32'h10);
        set_fwd(2, 5'd1, 1'b1, 32'h99);
`ifdef DS_FWD_EN
        eval();
        check("prio_to_es_valid", 32'(ds_to_es_valid), 32'd1);
        check("prio_src1", ds_src1, 32'h10);
        adv();
`else
        eval();
        check("prio_stall_a", 32'(ds_to_es_valid), 32'd0);
        adv();
        fwd_valid[0] = 1'b0;
        eval();
        check("prio_stall_b", 32'(ds_to_es_valid), 32'd0);
        adv();
        fwd_valid[2] = 1'b0;
        eval();
        check("prio_to_es_valid", 32'(ds_to_es_valid), 32'd1);
        check("prio_src1", ds_src1, rf[1]);
        check("prio_stall_cnt", stall_cnt, 32'd2);
        adv();
`endif

        // Load-use on r5 from source 0
        do_reset();
        load({10'h00a, 12'h000, 5'd5, 5'd3}, 32'h1c00_0008);
        set_fwd(0, 5'd5, 1'b0, 32'h0);
        eval();
        check("lu_stall", 32'(ds_to_es_valid), 32'd0);
        adv();
        fwd_ready[0] = 1'b1;
        fwd_wdata[XLEN-1:0] = 32'hABCD;
`ifdef DS_FWD_EN
        eval();
        check("lu_to_es_valid", 32'(ds_to_es_valid), 32'd1);
        check("lu_stall_cnt", stall_cnt, 32'd1);
        check("lu_src1", ds_src1, 32'hABCD);
        adv();
`else
        eval();
        check("lu_hold", 32'(ds_to_es_valid), 32'd0);
        adv();
        idle();
        rf[5] = 32'hABCD;
        eval();
        check("lu_to_es_valid", 32'(ds_to_es_valid), 32'd1);
        check("lu_stall_cnt", stall_cnt, 32'd2);
        check("lu_src1", ds_src1, 32'hABCD);
        adv();
`endif

        // Reset during a stall drops the instruction
        set_fwd(0, 5'd5, 1'b0, 32'h0);
        load({10'h00a, 12'h000, 5'd5, 5'd3}, 32'h1c00_000c);
        set_fwd(0, 5'd5, 1'b0, 32'h0);
        reset = 1'b1;
        eval();
        check("rst_stall_br", 32'(br_taken), 32'd0);
        adv();
        idle();
        eval();
        check("rst_stall_valid", 32'(ds_to_es_valid), 32'd0);
        adv();

        // Signed vs unsigned compares, beq target
        rf[1] = 32'hFFFF_FFFF;
        rf[2] = 32'h1;
        load(br_inst(6'h18, 5'd1, 5'd2, 16'h0010), 32'h200);
        eval();
        check("blt_taken", 32'(br_taken), 32'd1);
        check("blt_target", br_target, 32'h240);
        adv();
        load(br_inst(6'h1a, 5'd1, 5'd2, 16'h0010), 32'h300);
        eval();
        check("bltu_not_taken", 32'(br_taken), 32'd0);
        check("bltu_to_es_valid", 32'(ds_to_es_valid), 32'd1);
        adv();
        load(br_inst(6'h16, 5'd0, 5'd0, 16'h0004), 32'h100);
        eval();
        check("beq_taken", 32'(br_taken), 32'd1);
        check("beq_target", br_target, 32'h110);
        adv();

        // jirl held three cycles, then redirects once and squashes the fetch
        do_reset();
`ifdef DS_FWD_EN
        rf[4] = 32'h7777;
`else
        rf[4] = 32'h2000;
`endif
        load(br_inst(6'h13, 5'd4, 5'd1, 16'hFFFF), 32'h400);
`ifdef DS_FWD_EN
        set_fwd(1, 5'd4, 1'b1, 32'h2000);
`endif
        es_allow_in = 1'b0;
        fs_valid = 1'b1; fs_inst = add_w(5'd3, 5'd1, 5'd2); fs_pc = 32'h500;
        for (int k = 0; k < 3; k++) begin
            eval();
            check("jirl_hold_br", 32'(br_taken), 32'd0);
            check("jirl_hold_allow", 32'(ds_allow_in), 32'd0);
            adv();
        end
        es_allow_in = 1'b1;
        eval();
        check("jirl_br_taken", 32'(br_taken), 32'd1);
        check("jirl_target", br_target, 32'h1FFC);
        adv();
        fs_valid = 1'b0;
        eval();
        check("jirl_squash", 32'(ds_to_es_valid), 32'd0);
        check("jirl_single_pulse", 32'(br_taken), 32'd0);
        adv();

        // r0 writes never interlock and r0 reads as zero
        do_reset();
        rf[0] = 32'h5555;
        load(add_w(5'd3, 5'd0, 5'd0), 32'h600);
        for (int i = 0; i < NUM_FWD; i++) set_fwd(i, 5'd0, 1'b0, 32'hDEAD);
        eval();
        check("r0_to_es_valid", 32'(ds_to_es_valid), 32'd1);
        check("r0_src1", ds_src1, 32'h0);
        check("r0_src2", ds_src2, 32'h0);
        adv();

        // Randomized traffic against the model
        for (int c = 0; c < 3000; c++) begin
            reset       = ($urandom_range(0, 199) == 0);
            fs_valid    = ($urandom_range(0, 9) < 7);
            fs_pc       = $urandom;
            fs_inst     = rand_inst();
            es_allow_in = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < NUM_FWD; i++) begin
                fwd_valid[i] = ($urandom_range(0, 1) == 1);
                fwd_we[i]    = ($urandom_range(0, 9) < 7);
                fwd_ready[i] = ($urandom_range(0, 9) < 6);
                fwd_waddr[5*i +: 5]       = 5'($urandom_range(0, 5));
                fwd_wdata[XLEN*i +: XLEN] = $urandom;
            end
            if ($urandom_range(0, 7) == 0) rf[$urandom_range(0, 31)] = $urandom;
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
